vend_sequencer: RTL

Top-level transaction sequencer for the vending machine. Drives the 2-bit machine `state` and `curIndex` consumed by the payment block, and owns the per-item inventory counters. Answers the payment block's `changeState`/`reduceInventory` requests and issues/retires `cancelled` through four-phase handshakes. Also handles item selection, payment timeout and restocking.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/vend_inventory.sv | 52 +++++
 rtl/vend_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction sequencer and its inventory bank.
`default_nettype none

package vend_pkg;

  typedef enum logic [1:0] {
    ST_SELECT = 2'b00,
    ST_PAY    = 2'b01,
    ST_VEND   = 2'b10,
    ST_CANCEL = 2'b11
  } state_e;

  localparam int NUM_ITEMS_DEF  = 8;
  localparam int INV_W_DEF      = 4;
  localparam int INIT_STOCK_DEF = 5;
  // Item index width is also used by the payment block
  localparam int IDX_W          = 4;

endpackage

`default_nettype wire

// File: rtl/vend_inventory.sv
// Per-item inventory counter bank: absolute restock writes, saturating decrement, combinational read.
`default_nettype none

module vend_inventory
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = NUM_ITEMS_DEF,
  parameter int INV_W      = INV_W_DEF,
  parameter int INIT_STOCK = INIT_STOCK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [INV_W-1:0] i_wr_data,
  input  logic             i_dec_en,
  input  logic [IDX_W-1:0] i_dec_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [INV_W-1:0] o_rd_count
);

  logic [INV_W-1:0] r_count [NUM_ITEMS];

  // A restock landing on the item being decremented overrides the decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        r_count[i] <= INV_W'(INIT_STOCK);
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
          r_count[i] <= i_wr_data;
        end else if (i_dec_en && (i_dec_idx == IDX_W'(i)) && (r_count[i] != '0)) begin
          r_count[i] <= r_count[i] - INV_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_rd_count = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (i_rd_idx == IDX_W'(i)) begin
        o_rd_count = r_count[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: selection, payment timeout, vend/cancel handshakes with the payment block.
`default_nettype none

module vend_sequencer
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = NUM_ITEMS_DEF,
  parameter int INV_W      = INV_W_DEF,
  parameter int INIT_STOCK = INIT_STOCK_DEF,
  parameter int TIMEOUT    = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select_valid,
  input  logic [IDX_W-1:0] select_idx,
  input  logic             cancel_req,
  input  logic             restock_valid,
  input  logic [IDX_W-1:0] restock_idx,
  input  logic [INV_W-1:0] restock_count,
  input  logic             changeState,
  output logic             changeStateDone,
  input  logic             reduceInventory,
  output logic             reduceInventoryDone,
  output logic             cancelled,
  input  logic             cancelledDone,
  output logic [1:0]       state,
  output logic [IDX_W-1:0] curIndex,
  output logic             vend_pulse,
  output logic             sold_out
);

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_cur_idx;
  logic [7:0]       r_timer;
  logic             r_rid_done;
  logic             r_cs_done;
  logic             r_cancelled;
  logic             r_vend_pulse;
  logic             r_sold_out;

  logic             w_sel_in_range;
  logic             w_rst_in_range;
  logic             w_purchase;
  logic [INV_W-1:0] w_sel_count;

  assign w_sel_in_range = int'(select_idx) < NUM_ITEMS;
  assign w_rst_in_range = int'(restock_idx) < NUM_ITEMS;
  // Purchase is accepted only on a fresh request, never on one already acknowledged
  assign w_purchase     = (r_state == ST_PAY) && reduceInventory && !r_rid_done;

  vend_inventory #(
    .NUM_ITEMS  (NUM_ITEMS),
    .INV_W      (INV_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_inv (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (restock_valid && w_rst_in_range),
    .i_wr_idx   (restock_idx),
    .i_wr_data  (restock_count),
    .i_dec_en   (w_purchase),
    .i_dec_idx  (r_cur_idx),
    .i_rd_idx   (select_idx),
    .o_rd_count (w_sel_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SELECT;
      r_cur_idx    <= '0;
      r_timer      <= '0;
      r_rid_done   <= 1'b0;
      r_cs_done    <= 1'b0;
      r_cancelled  <= 1'b0;
      r_vend_pulse <= 1'b0;
      r_sold_out   <= 1'b0;
    end else begin
      r_cs_done    <= changeState;
      r_vend_pulse <= 1'b0;
      r_sold_out   <= 1'b0;
      case (r_state)
        ST_SELECT: begin
          if (select_valid && w_sel_in_range) begin
            if (w_sel_count == '0) begin
              r_sold_out <= 1'b1;
            end else begin
              r_cur_idx <= select_idx;
              r_timer   <= '0;
              r_state   <= ST_PAY;
            end
          end
        end
        ST_PAY: begin
          r_timer <= r_timer + 8'd1;
          if (w_purchase) begin
            r_state      <= ST_VEND;
            r_vend_pulse <= 1'b1;
            r_rid_done   <= 1'b1;
          end else if (cancel_req || (r_timer == C_TMO_LAST)) begin
            r_state     <= ST_CANCEL;
            r_cancelled <= 1'b1;
          end
        end
        ST_VEND: begin
          if (!reduceInventory) begin
            r_rid_done <= 1'b0;
            r_state    <= ST_SELECT;
          end
        end
        ST_CANCEL: begin
          if (cancelledDone && r_cancelled) begin
            r_cancelled <= 1'b0;
          end else if (!cancelledDone && !r_cancelled) begin
            r_state <= ST_SELECT;
          end
        end
        default: r_state <= ST_SELECT;
      endcase
    end
  end

  assign state               = r_state;
  assign curIndex            = r_cur_idx;
  assign changeStateDone     = r_cs_done;
  assign reduceInventoryDone = r_rid_done;
  assign cancelled           = r_cancelled;
  assign vend_pulse          = r_vend_pulse;
  assign sold_out            = r_sold_out;

endmodule

`default_nettype wire
